// File: rtl/temp_buf_ctrl_if.sv
// Signal bundle between temp_buf_ctrl and its neighbours: MAC input stream, temp BRAM port, next-layer stream.
// Signal suffixes are from the controller's point of view; "master" is the controller, "slave" the environment.
interface temp_buf_ctrl_if #(
  parameter int MAC_CNT    = 128,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = $clog2(MAC_CNT)
);
  logic                  start_i;
  logic                  in_valid_i;
  logic [DATA_WIDTH-1:0] in_data_i;
  logic                  in_ready_o;
  logic                  wr_temp_en_o;
  logic [ADDR_WIDTH-1:0] temp_wr_addr_o;
  logic [DATA_WIDTH-1:0] temp_wdata_o;
  logic                  rd_temp_en_o;
  logic [ADDR_WIDTH-1:0] temp_rd_addr_o;
  logic                  clear_o;
  logic [DATA_WIDTH-1:0] temp_rdata_i;
  logic                  out_valid_o;
  logic [DATA_WIDTH-1:0] out_data_o;
  logic                  out_last_o;
  logic                  out_ready_i;
  logic                  busy_o;
  logic                  done_o;

  modport master (
    input  start_i, in_valid_i, in_data_i, temp_rdata_i, out_ready_i,
    output in_ready_o, wr_temp_en_o, temp_wr_addr_o, temp_wdata_o,
           rd_temp_en_o, temp_rd_addr_o, clear_o,
           out_valid_o, out_data_o, out_last_o, busy_o, done_o
  );

  modport slave (
    output start_i, in_valid_i, in_data_i, temp_rdata_i, out_ready_i,
    input  in_ready_o, wr_temp_en_o, temp_wr_addr_o, temp_wdata_o,
           rd_temp_en_o, temp_rd_addr_o, clear_o,
           out_valid_o, out_data_o, out_last_o, busy_o, done_o
  );
endinterface

// File: rtl/temp_buf_ctrl.sv
// Fills the MAC temp BRAM with one frame, then drains it in address order through a 2-entry output FIFO.
// Define TEMP_BUF_CLEAR_EN to add a CLEAR state that zeroes the BRAM after every frame.
module temp_buf_ctrl #(
  parameter int MAC_CNT    = 128,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = $clog2(MAC_CNT)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  temp_buf_ctrl_if.master bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
`ifdef TEMP_BUF_CLEAR_EN
  localparam logic [1:0] CLEAR = 2'd3;
`endif

  localparam logic [ADDR_WIDTH:0] ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] CNT_END  = MAC_CNT[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] LAST_IDX = CNT_END - ONE;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH:0]   wrIdx_q, wrIdx_d;
  logic [ADDR_WIDTH:0]   rdIdx_q, rdIdx_d;
  logic                  wrEn_q, wrEn_d;
  logic [ADDR_WIDTH-1:0] wrAddr_q, wrAddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                       inFlight_q, inFlightLast_q;
  logic [1:0][DATA_WIDTH-1:0] fifoData_q;
  logic [1:0]                 fifoLast_q;
  logic                       fifoWrPtr_q, fifoRdPtr_q;
  logic [1:0]                 fifoCnt_q;

  logic inFire, pop, lastPop, rdIssue, fifoValid;

  assign inFire    = (state_q == FILL) && bus.in_valid_i;
  assign fifoValid = (fifoCnt_q != 2'd0);
  assign pop       = fifoValid && bus.out_ready_i;
  assign lastPop   = pop && fifoLast_q[fifoRdPtr_q];

  // Reads wait out the final write and never commit more words than the FIFO can still hold.
  assign rdIssue = (state_q == DRAIN) && (rdIdx_q < CNT_END) && !wrEn_q &&
                   (({1'b0, fifoCnt_q} + {2'b00, inFlight_q} - {2'b00, pop}) < 3'd2);

  always_comb begin
    state_d  = state_q;
    wrIdx_d  = wrIdx_q;
    rdIdx_d  = rdIdx_q;
    wrEn_d   = 1'b0;
    wrAddr_d = '0;
    wdata_d  = '0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = FILL;
          wrIdx_d = '0;
          rdIdx_d = '0;
        end
      end
      FILL: begin
        if (inFire) begin
          wrEn_d   = 1'b1;
          wrAddr_d = wrIdx_q[ADDR_WIDTH-1:0];
          wdata_d  = bus.in_data_i;
          wrIdx_d  = wrIdx_q + ONE;
          if (wrIdx_q == LAST_IDX) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (rdIssue) rdIdx_d = rdIdx_q + ONE;
`ifdef TEMP_BUF_CLEAR_EN
        if (lastPop) state_d = CLEAR;
`else
        if (lastPop) state_d = IDLE;
`endif
      end
`ifdef TEMP_BUF_CLEAR_EN
      CLEAR: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      wrIdx_q  <= '0;
      rdIdx_q  <= '0;
      wrEn_q   <= 1'b0;
      wrAddr_q <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wrIdx_q  <= wrIdx_d;
      rdIdx_q  <= rdIdx_d;
      wrEn_q   <= wrEn_d;
      wrAddr_q <= wrAddr_d;
      wdata_q  <= wdata_d;
    end
  end

  // BRAM data arrives one cycle after the read enable and is pushed at the end of that cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inFlight_q     <= 1'b0;
      inFlightLast_q <= 1'b0;
      fifoData_q     <= '0;
      fifoLast_q     <= '0;
      fifoWrPtr_q    <= 1'b0;
      fifoRdPtr_q    <= 1'b0;
      fifoCnt_q      <= 2'd0;
    end else begin
      inFlight_q     <= rdIssue;
      inFlightLast_q <= rdIssue && (rdIdx_q == LAST_IDX);
      if (inFlight_q) begin
        fifoData_q[fifoWrPtr_q] <= bus.temp_rdata_i;
        fifoLast_q[fifoWrPtr_q] <= inFlightLast_q;
        fifoWrPtr_q             <= ~fifoWrPtr_q;
      end
      if (pop) fifoRdPtr_q <= ~fifoRdPtr_q;
      fifoCnt_q <= fifoCnt_q + {1'b0, inFlight_q} - {1'b0, pop};
    end
  end

  assign bus.in_ready_o     = (state_q == FILL);
  assign bus.wr_temp_en_o   = wrEn_q;
  assign bus.temp_wr_addr_o = wrAddr_q;
  assign bus.temp_wdata_o   = wdata_q;
  assign bus.rd_temp_en_o   = rdIssue;
  assign bus.temp_rd_addr_o = rdIssue ? rdIdx_q[ADDR_WIDTH-1:0] : '0;
  assign bus.out_valid_o    = fifoValid;
  assign bus.out_data_o     = fifoValid ? fifoData_q[fifoRdPtr_q] : '0;
  assign bus.out_last_o     = fifoValid && fifoLast_q[fifoRdPtr_q];
  assign bus.busy_o         = (state_q != IDLE);

`ifdef TEMP_BUF_CLEAR_EN
  assign bus.clear_o = (state_q == CLEAR);
  assign bus.done_o  = (state_q == CLEAR);
`else
  logic done_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) done_q <= 1'b0;
    else       done_q <= lastPop;
  end

  assign bus.clear_o = 1'b0;
  assign bus.done_o  = done_q;
`endif

endmodule

// File: tb/tb_temp_buf_ctrl.sv
// Self-checking bench for temp_buf_ctrl: directed and random frames against a queue-based frame model
// with a simple BRAM model attached to the controller's port.
module tb_temp_buf_ctrl;

  localparam int MAC_CNT    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = $clog2(MAC_CNT);
`ifdef TEMP_BUF_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  temp_buf_ctrl_if #(.MAC_CNT(MAC_CNT), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  temp_buf_ctrl #(.MAC_CNT(MAC_CNT), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk_i (clock),
    .rst_i (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Temp BRAM: one-cycle read latency, read data is zero when no read was issued.
  logic [DATA_WIDTH-1:0] mem [MAC_CNT];
  always @(posedge clock) begin
    if (bus.wr_temp_en_o) mem[bus.temp_wr_addr_o] <= bus.temp_wdata_o;
    if (bus.clear_o) for (int i = 0; i < MAC_CNT; i++) mem[i] <= '0;
    bus.temp_rdata_i <= bus.rd_temp_en_o ? mem[bus.temp_rd_addr_o] : '0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic valid, input logic [DATA_WIDTH-1:0] data,
                               input logic ready);
    bus.start_i     = start;
    bus.in_valid_i  = valid;
    bus.in_data_i   = data;
    bus.out_ready_i = ready;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput(tag, {bus.in_ready_o, bus.wr_temp_en_o, bus.temp_wr_addr_o, bus.temp_wdata_o,
                      bus.rd_temp_en_o, bus.temp_rd_addr_o, bus.clear_o, bus.out_valid_o,
                      bus.out_data_o, bus.out_last_o, bus.busy_o, bus.done_o}, 32'h0);
  endtask

  // validMode: 0 always, 1 toggling, 2 random. readyMode: 0 always, 1 random, 2 five-cycle stall.
  task automatic runFrame(input int validMode, input int readyMode, input bit startPulses,
                          input int abortCycle, input bit fixedData);
    logic [DATA_WIDTH-1:0] sent[$];
    logic [DATA_WIDTH-1:0] d;
    logic v, r, s, popNow;
    int acc, nReads, nPops, stallUsed, cyc, readsOneAgo, readsTwoAgo;
    bit pendWr, prevLastPop, finished, streaming;
    acc = 0; nReads = 0; nPops = 0; stallUsed = 0; cyc = 0;
    readsOneAgo = 0; readsTwoAgo = 0;
    pendWr = 0; prevLastPop = 0; finished = 0;
    streaming = (validMode == 0) && (readyMode == 0);

    @(negedge clock);
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    #1;
    checkOutput("idle_in_ready", bus.in_ready_o, 0);
    checkOutput("idle_busy", bus.busy_o, 0);

    while (!finished && cyc < 300) begin
      @(negedge clock);
      cyc++;
      if (abortCycle != 0 && cyc == abortCycle) begin
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        reset = 1'b1;
        #1;
        checkAllZero("reset_mid_drain");
        @(negedge clock);
        reset = 1'b0;
        repeat (3) begin
          @(negedge clock);
          #1;
          checkOutput("post_reset_quiet", {bus.wr_temp_en_o, bus.rd_temp_en_o, bus.clear_o,
                                           bus.out_valid_o, bus.busy_o}, 0);
        end
        return;
      end

      case (validMode)
        0:       v = 1'b1;
        1:       v = cyc[0];
        default: v = 1'($urandom_range(0, 1));
      endcase
      case (readyMode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 3) != 0);
        default: begin
          r = !(nPops == 1 && stallUsed < 5);
          if (!r) stallUsed++;
        end
      endcase
      d = fixedData ? DATA_WIDTH'((acc + 1) * 17) : DATA_WIDTH'($urandom);
      s = startPulses && (cyc == 2);
      applyStimulus(s, v, d, r);
      #1;

      checkOutput("wr_en", bus.wr_temp_en_o, pendWr);
      if (pendWr) begin
        checkOutput("wr_addr", bus.temp_wr_addr_o, acc - 1);
        checkOutput("wr_data", bus.temp_wdata_o, sent[acc-1]);
      end
      checkOutput("in_ready", bus.in_ready_o, acc < MAC_CNT);
      checkOutput("busy", bus.busy_o, prevLastPop ? CLEAR_EN : 1'b1);
      checkOutput("enable_overlap",
                  (32'(bus.wr_temp_en_o) + 32'(bus.rd_temp_en_o) + 32'(bus.clear_o)) <= 1, 1);
      checkOutput("out_valid", bus.out_valid_o, readsTwoAgo > nPops);

      popNow = bus.out_valid_o && r;
      if (bus.rd_temp_en_o) begin
        checkOutput("rd_addr", bus.temp_rd_addr_o, nReads);
        checkOutput("rd_after_fill", (acc == MAC_CNT) && !pendWr, 1);
        if (streaming && nReads == 0) checkOutput("first_read_cycle", cyc, MAC_CNT + 2);
        nReads++;
        checkOutput("read_ahead", (nReads - nPops - 32'(popNow)) <= 2, 1);
      end
      if (popNow) begin
        checkOutput("out_count", nPops < acc, 1);
        checkOutput("out_data", bus.out_data_o, (nPops < sent.size()) ? sent[nPops] : '0);
        checkOutput("out_last", bus.out_last_o, nPops == MAC_CNT - 1);
        if (streaming) checkOutput("pop_cycle", cyc, MAC_CNT + 4 + nPops);
        nPops++;
      end
      checkOutput("done", bus.done_o, prevLastPop);
      checkOutput("clear", bus.clear_o, CLEAR_EN && prevLastPop);
      if (prevLastPop) finished = 1;

      pendWr = v && (acc < MAC_CNT);
      if (pendWr) begin
        sent.push_back(d);
        acc++;
      end
      prevLastPop = popNow && (nPops == MAC_CNT);
      readsTwoAgo = readsOneAgo;
      readsOneAgo = nReads;
    end
    checkOutput("frame_timeout", finished, 1);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    #2 reset = 1'b1;
    #2;
    checkAllZero("reset_state");
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    runFrame(0, 0, 1'b0, 0, 1'b1);
    runFrame(1, 0, 1'b0, 0, 1'b0);
    runFrame(0, 2, 1'b0, 0, 1'b0);
    runFrame(2, 1, 1'b1, 0, 1'b0);
    runFrame(0, 0, 1'b0, MAC_CNT + 5, 1'b0);
    runFrame(0, 0, 1'b0, 0, 1'b1);
    for (int f = 0; f < 6; f++) runFrame(2, 1, f[0], 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
